// File: rtl/msg_scheduler.sv
// SHA-256 message schedule: loads 16 message words, then streams W[0..63]
// with their round index, expanding W[16..63] from a 16-word sliding window.
module msg_scheduler #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_out,
    output logic [5:0]        wi_out,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fsm_state
);

    // Handshakes: a word moves when valid & ready are both high at a rising edge;
    // in_ready depends only on state and w_valid only on registers, never on the peer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [3:0]                   cnt;
    logic [15:0][WORD_W-1:0]      win;
    logic [WORD_W-1:0]            w_next;
    logic                         in_fire;
    logic                         w_fire;
    logic                         load_last;
    logic                         emit_last;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign in_fire   = in_valid & in_ready;
    assign w_fire    = w_valid & w_ready;
    assign load_last = in_fire && (cnt == 4'd15);
    assign emit_last = w_fire && (wi_out == 6'(ROUNDS - 1));

    // win[0] is the word on w_out; win[k] is W[t+k], so W[t+16] comes from taps 0,1,9,14.
    assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = LOAD;
            LOAD:    if (load_last) state_nxt = EMIT;
            EMIT:    if (emit_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD);
        busy      = ((state == LOAD) && (cnt != 4'd0)) || (state == EMIT);
        fsm_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            win     <= '0;
            w_valid <= 1'b0;
            w_out   <= '0;
            wi_out  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_fire) begin
                win[cnt] <= in_word;
                cnt      <= cnt + 4'd1;
            end
            if (state == EMIT) begin
                // The first EMIT cycle only primes the output register.
                if (!w_valid) begin
                    w_valid <= 1'b1;
                    w_out   <= win[0];
                    wi_out  <= '0;
                end else if (w_fire) begin
                    win <= {w_next, win[15:1]};
                    if (emit_last) begin
                        w_valid <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        w_out  <= win[1];
                        wi_out <= wi_out + 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_msg_scheduler.sv
// Bench for msg_scheduler: table of blocks (fixed and random) checked against
// a direct SHA-256 schedule model, plus a mid-block reset sequence.
module tb_msg_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        w_valid;
    logic        w_ready = 1'b0;
    logic [31:0] w_out;
    logic [5:0]  wi_out;
    logic        busy;
    logic        done;
    logic [1:0]  fsm_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] blk[16];

    typedef struct {
        int          kind;       // 0 hello, 1 zero, 2 random
        int          ready_pct;
        int          gap;
        logic        chk_w16;
        logic [31:0] exp_w16;
    } vec_t;

    vec_t vecs[6];

    msg_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .wi_out    (wi_out),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // reference model: schedule computed straight from the definition
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_expected();
        logic [31:0] w[64];
        logic [31:0] s0;
        logic [31:0] s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = blk[t];
            end else begin
                s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
            exp_q.push_back(w[t]);
        end
    endtask

    task automatic set_block(input int kind);
        for (int i = 0; i < 16; i++) blk[i] = '0;
        case (kind)
            0: begin
                blk[0]  = 32'h48656c6c;
                blk[1]  = 32'h6f20776f;
                blk[2]  = 32'h726c6421;
                blk[3]  = 32'h80000000;
                blk[15] = 32'h00000060;
            end
            1: ;
            default: for (int i = 0; i < 16; i++) blk[i] = $urandom;
        endcase
    endtask

    // driver: offers one word every 'gap' cycles until 16 are taken
    task automatic load_block(input int gap);
        int idx = 0;
        int cyc = 0;
        while (idx < 16 && cyc < 500) begin
            @(negedge clk);
            in_valid = ((cyc % gap) == 0);
            in_word  = blk[idx];
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        if (idx < 16) begin
            checks++;
            errors++;
            $display("FAIL load_timeout taken=%0d required=16", idx);
        end
    endtask

    // scoreboard: drains 64 words with random back-pressure, then checks DONE and re-arm
    task automatic drain(input int ready_pct, input logic chk16, input logic [31:0] e16);
        int          got = 0;
        int          cyc = 0;
        int          first = 0;
        logic        stall = 1'b0;
        logic [31:0] hw = '0;
        logic [5:0]  hi = '0;
        logic [31:0] e;
        while (got < 64 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("busy_emit", 32'(busy), 32'd1);
                in_word = $urandom;
            end
            if (w_valid && first == 0) begin
                first = cyc;
                chk("first_valid_cycle", 32'(cyc), 32'd2);
            end
            if (w_valid && stall) begin
                chk("stall_w_out", w_out, hw);
                chk("stall_wi_out", 32'(wi_out), 32'(hi));
            end
            chk("done_low", 32'(done), 32'd0);
            w_ready = ($urandom_range(99) < ready_pct);
            if (w_valid && w_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdeadbeef;
                chk("w_out", w_out, e);
                chk("wi_out", 32'(wi_out), 32'(got));
                if (got == 16 && chk16) chk("w16", w_out, e16);
                got++;
                stall = 1'b0;
            end else if (w_valid) begin
                stall = 1'b1;
                hw    = w_out;
                hi    = wi_out;
            end
        end
        if (got < 64) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d required=64", got);
        end
        @(negedge clk);
        w_ready  = 1'b0;
        in_valid = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("w_valid_after_last", 32'(w_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("in_ready_idle", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("in_ready_rearm", 32'(in_ready), 32'd1);
        chk("busy_load_empty", 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{0, 100, 1, 1'b1, 32'h17470237};
        vecs[1] = '{1, 100, 1, 1'b1, 32'h00000000};
        vecs[2] = '{0, 50,  1, 1'b1, 32'h17470237};
        vecs[3] = '{0, 100, 3, 1'b1, 32'h17470237};
        vecs[4] = '{2, 70,  2, 1'b0, 32'h0};
        vecs[5] = '{2, 100, 1, 1'b0, 32'h0};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_w_out", w_out, 32'd0);
        chk("rst_wi_out", 32'(wi_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // table-driven blocks, each following the previous one back-to-back
        for (int v = 0; v < 6; v++) begin
            set_block(vecs[v].kind);
            build_expected();
            load_block(vecs[v].gap);
            drain(vecs[v].ready_pct, vecs[v].chk_w16, vecs[v].exp_w16);
        end

        // mid-block reset at WI_OUT=30
        begin
            bit found = 1'b0;
            int cyc = 0;
            set_block(0);
            load_block(1);
            while (!found && cyc < 500) begin
                @(negedge clk);
                cyc++;
                if (w_valid && wi_out == 6'd30) found = 1'b1;
                else w_ready = 1'b1;
            end
            w_ready  = 1'b0;
            in_valid = 1'b0;
            chk("reach_wi30", 32'(found), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            chk("abort_w_valid", 32'(w_valid), 32'd0);
            chk("abort_wi_out", 32'(wi_out), 32'd0);
            chk("abort_w_out", w_out, 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            repeat (2) begin
                @(negedge clk);
                chk("abort_no_done", 32'(done), 32'd0);
            end
            rst_n = 1'b1;
            chk("release_in_ready", 32'(in_ready), 32'd0);
            exp_q.delete();
        end

        set_block(0);
        build_expected();
        load_block(1);
        drain(100, 1'b1, 32'h17470237);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
